// File: rtl/mips_mdu.sv
// Iterative radix-2 multiply/divide unit holding the MIPS HI/LO registers.
// Define MIPS_MDU_FAST_MUL_EN to execute MULT/MULTU in a single combinational step.
module mips_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_e,
    input  logic [1:0]       op_e,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    input  logic             mthi_e,
    input  logic             mtlo_e,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     opnd_reg;
    logic [WIDTH-1:0]     dvd_raw_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 is_div_reg;
    logic                 neg_res_reg;
    logic                 neg_rem_reg;
    logic                 div0_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 done_reg;

    // Operand magnitudes; unsigned ops (op_e[0]=1) pass operands through raw.
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign a_neg = ~op_e[0] & srca_e[WIDTH-1];
    assign b_neg = ~op_e[0] & srcb_e[WIDTH-1];
    assign a_mag = a_neg ? (~srca_e + 1'b1) : srca_e;
    assign b_mag = b_neg ? (~srcb_e + 1'b1) : srcb_e;

    logic                 fast_mul_go;
`ifdef MIPS_MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0]   fast_mag;
    logic [2*WIDTH-1:0]   fast_prod;
    assign fast_mul_go = start_e & ~op_e[1];
    assign fast_mag    = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    assign fast_prod   = (a_neg ^ b_neg) ? (~fast_mag + 1'b1) : fast_mag;
`else
    assign fast_mul_go = 1'b0;
`endif

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                      (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_ge    = (div_shift >= {1'b0, opnd_reg});
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_ge};

    // Sign fix-up of the finished magnitudes.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign prod_fix = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign quo_fix  = neg_res_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_rem_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                                  : acc_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_e && !fast_mul_go) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            dvd_raw_reg <= '0;
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_e) begin
`ifdef MIPS_MDU_FAST_MUL_EN
                        if (fast_mul_go) begin
                            hi_reg   <= fast_prod[2*WIDTH-1:WIDTH];
                            lo_reg   <= fast_prod[WIDTH-1:0];
                            done_reg <= 1'b1;
                        end
`endif
                        // Multiply keeps the multiplier in the low half; divide the dividend.
                        acc_reg     <= {{WIDTH{1'b0}}, (op_e[1] ? a_mag : b_mag)};
                        opnd_reg    <= op_e[1] ? b_mag : a_mag;
                        dvd_raw_reg <= srca_e;
                        cnt_reg     <= CW'(WIDTH);
                        is_div_reg  <= op_e[1];
                        neg_res_reg <= a_neg ^ b_neg;
                        neg_rem_reg <= a_neg;
                        div0_reg    <= (srcb_e == '0);
                    end else begin
                        if (mthi_e) hi_reg <= srca_e;
                        if (mtlo_e) lo_reg <= srca_e;
                    end
                end
                RUN: begin
                    acc_reg <= is_div_reg ? div_next : mul_next;
                    cnt_reg <= cnt_reg - CW'(1);
                end
                FIX: begin
                    done_reg <= 1'b1;
                    if (!is_div_reg) begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end else if (div0_reg) begin
                        hi_reg <= dvd_raw_reg;
                        lo_reg <= '1;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: doc/mips_mdu.md
# mips_mdu

Parametrised iterative multiply/divide unit for the pipelined MIPS core, executing MULT, MULTU, DIV and DIVU and holding the architectural HI/LO registers. It sits beside the execute-stage ALU, accepts an operation when idle, and raises `busy` so the hazard logic stalls any later MDU instruction or HI/LO access until the result is committed. Operand width is a parameter; the single-cycle multiplier is a compile-time option.

## Interface
- `WIDTH`, 32, operand, HI and LO width (even, ≥ 4)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start_e`  in  1  launch the operation in `op_e` (sampled only in IDLE)
- `op_e`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `srca_e`  in  WIDTH  multiplicand or dividend (rs)
- `srcb_e`  in  WIDTH  multiplier or divisor (rt)
- `mthi_e`  in  1  write `srca_e` to HI
- `mtlo_e`  in  1  write `srca_e` to LO
- `busy`  out  1  operation in progress; pipeline stall request
- `done`  out  1  one-cycle pulse: HI/LO were written by an operation on the preceding edge
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX. Reset forces IDLE and sets `hi`=`lo`=0, `busy`=0, `done`=0.
- IDLE with `start_e`=1: latch magnitudes of `srca_e`/`srcb_e` (two's-complement absolute value for MULT/DIV, raw for MULTU/DIVU), latch the result-sign flags, load the iteration counter with WIDTH, go to RUN.
- RUN: one radix-2 step per cycle. Multiply: shift-add into a 2·WIDTH accumulator. Divide: restoring shift-subtract producing quotient and remainder. The counter decrements; at 1 go to FIX.
- FIX: apply signs and write HI/LO, pulse `done`, return to IDLE.
  - Multiply: {hi,lo} = 2·WIDTH product, negated if the operand signs differ (signed only).
  - Divide: lo = quotient, negated if the signs differ; hi = remainder, taking the sign of the dividend.
  - Divisor zero (any divide): lo = all ones, hi = `srca_e` as latched. Full latency is still taken.
  - DIV of −2^(WIDTH−1) by −1: lo = −2^(WIDTH−1) (wraps), hi = 0.
- `mthi_e`/`mtlo_e` act in IDLE only and take effect on the next edge. Both may be asserted in the same cycle.
- Simultaneous `start_e` with `mthi_e`/`mtlo_e` in IDLE: start wins and the moves are dropped.
- Outside IDLE, `start_e`, `mthi_e` and `mtlo_e` are ignored. HI/LO keep their old values until FIX.
- Reset asserted mid-operation aborts it immediately. No partial result reaches HI/LO.

## Timing
- Start accepted on the edge ending cycle N.
- `busy`=1 during cycles N+1 … N+WIDTH+1: WIDTH RUN cycles plus FIX.
- HI/LO are updated on the edge ending cycle N+WIDTH+1. New values and `done`=1 are visible in cycle N+WIDTH+2, with `busy`=0.
- A new start is therefore accepted at the earliest in cycle N+WIDTH+2. Back-to-back operations are spaced WIDTH+2 cycles apart.
- `busy` is registered (no combinational path from `start_e`). The hazard unit stalls the instruction following the starting one combinationally from its own decode.
- HI/LO outputs are register outputs: zero-latency reads, no bypass of in-flight results.

## Configuration
- `MIPS_MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a combinational WIDTH×WIDTH multiplier. The product is written to HI/LO on the start edge, with `done`=1 the next cycle.
  - `busy` is never asserted for multiplies and the state stays IDLE.
  - Divides are unchanged.
- Not defined: multiplies use the iterative RUN/FIX path with the same latency as divides.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32, iterative): `busy` high exactly 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, `done` for 1 cycle.
- MULT −3 × 5: hi=0xFFFFFFFF, lo=0xFFFFFFF1. With `MIPS_MDU_FAST_MUL_EN`: same values one cycle after start, `busy` never high.
- DIV −7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0: lo=0xFFFFFFFF, hi=0x00000007, after full latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- `start_e` with new operands and `mthi_e`=1 pulsed mid-operation: both ignored, the first result is intact. In IDLE, `mthi_e`=1 with srca=0x1234 gives hi=0x1234 next cycle. Asserting `start_e` and `mtlo_e` together leaves lo untouched by the move.
- `reset` low in cycle 10 of a DIVU: next cycle `busy`=0, hi=lo=0, `done`=0. A fresh DIVU 100/7 then yields lo=14, hi=2.
